// File: rtl/time_unit_counter_pkg.sv
// time_counter_pkg: shared constants and helpers for time_unit_counter.
//   - Prescaler terminal counts: real-time (1 s at 50 MHz) and per-unit
//     debug rates selected by dbg_rate when TIME_UNIT_DEBUG_RATE_EN is defined.
//   - edit_op_t: the digit edit requested by a key event.
//   - rate_tc():   dbg_rate -> terminal count.
//   - apply_edit(): the ones/tens digit edit with wrap inside [min, max].
package time_counter_pkg;

  localparam int unsigned TC_REALTIME   = 49_999_999;
  localparam int unsigned TC_DBG_MINUTE = 833_333;
  localparam int unsigned TC_DBG_HOUR   = 13_888;
  localparam int unsigned TC_DBG_DAY    = 578;
  localparam int unsigned TC_DBG_MONTH  = 19;
  localparam int unsigned TC_DBG_YEAR   = 1;

  typedef enum logic [2:0] {
    NONE,
    ONES_INC,
    ONES_DEC,
    TENS_INC,
    TENS_DEC
  } edit_op_t;

  // Rate 0 (and unused codes 6/7) fall back to the instance's own TC.
  function automatic int unsigned rate_tc(input logic [2:0] rate,
                                          input int unsigned base_tc);
    case (rate)
      3'd1:    return TC_DBG_MINUTE;
      3'd2:    return TC_DBG_HOUR;
      3'd3:    return TC_DBG_DAY;
      3'd4:    return TC_DBG_MONTH;
      3'd5:    return TC_DBG_YEAR;
      default: return base_tc;
    endcase
  endfunction

  // Digit edits wrap within the digit rather than carrying into the other one.
  function automatic int apply_edit(input edit_op_t op, input int v,
                                    input int min_val, input int max_val);
    int ones;
    int tens;
    int r;
    ones = v % 10;
    tens = v / 10;
    r    = v;
    case (op)
      ONES_INC: begin
        if (ones == 9 || v == max_val) begin
          r = v - ones;
          if (r < min_val) r = min_val;
        end else begin
          r = v + 1;
        end
      end
      ONES_DEC: begin
        if (ones == 0 || v == min_val) begin
          r = (max_val - tens * 10 < 9) ? max_val : tens * 10 + 9;
        end else begin
          r = v - 1;
        end
      end
      TENS_INC: begin
        if (v + 10 > max_val) begin
          r = (ones < min_val) ? min_val : ones;
        end else begin
          r = v + 10;
        end
      end
      TENS_DEC: begin
        if (v - 10 < min_val) begin
          r = (max_val / 10) * 10 + ones;
          if (r > max_val) r = max_val;
        end else begin
          r = v - 10;
        end
      end
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: falling-edge detector for one active-low key.
//   clk   - clock, rising edge
//   reset - synchronous, active-low
//   key   - raw key level (0 = pressed)
//   fall  - one-cycle pulse: previous sample 1, current level 0
module key_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic fall
);

  logic key_q;
  logic armed;

  // History comes out of reset as "released"; armed stays low for the first
  // post-reset edge so a key held through reset is captured, not reported.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q <= 1'b1;
      armed <= 1'b0;
    end else begin
      key_q <= key;
      armed <= 1'b1;
    end
  end

  assign fall = armed && key_q && !key;

endmodule

// File: rtl/time_unit_counter.sv
// time_unit_counter: one clock/calendar unit (seconds, minutes, day, ...).
// Counts MIN_VAL..MAX_VAL, advancing from an internal prescaler
// (INT_PRESCALE=1) or from tick_in, with digit edit keys and a preset load.
//   clk, reset          - clock; synchronous active-low reset
//   tick_in             - advance pulse from lower unit (INT_PRESCALE=0)
//   edit_mode, edit_sel - freeze counting and edit ones(0)/tens(1) digit
//   key_plus, key_minus - active-low edit keys
//   load_en, load_val   - preset, clamped into range
//   dbg_rate            - debug TC select, only with TIME_UNIT_DEBUG_RATE_EN
//   value, carry_out    - registered value and one-cycle wrap pulse
module time_unit_counter
  import time_counter_pkg::*;
#(
  parameter int unsigned MAX_VAL      = 59,
  parameter int unsigned MIN_VAL      = 0,
  parameter int unsigned WIDTH        = 7,
  parameter int unsigned INT_PRESCALE = 1,
  parameter int unsigned TICK_TC      = TC_REALTIME
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             edit_mode,
  input  logic             edit_sel,
  input  logic             key_plus,
  input  logic             key_minus,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
`ifdef TIME_UNIT_DEBUG_RATE_EN
  input  logic [2:0]       dbg_rate,
`endif
  output logic [WIDTH-1:0] value,
  output logic             carry_out
);

  logic ev_plus;
  logic ev_minus;

  key_edge_detect u_key_plus (
    .clk   (clk),
    .reset (reset),
    .key   (key_plus),
    .fall  (ev_plus)
  );

  key_edge_detect u_key_minus (
    .clk   (clk),
    .reset (reset),
    .key   (key_minus),
    .fall  (ev_minus)
  );

  logic [31:0] tc;
  logic        rate_changed;

`ifdef TIME_UNIT_DEBUG_RATE_EN
  logic [2:0] dbg_rate_q;

  always_ff @(posedge clk) begin
    dbg_rate_q <= dbg_rate;
  end

  assign tc           = rate_tc(dbg_rate, TICK_TC);
  assign rate_changed = (dbg_rate != dbg_rate_q);
`else
  assign tc           = TICK_TC;
  assign rate_changed = 1'b0;
`endif

  logic [31:0] presc;
  logic        advance;

  // A rate change restarts the count, so the old count is never compared
  // against the new terminal value.
  always_comb begin
    if (INT_PRESCALE != 0) advance = (presc == tc) && !rate_changed;
    else                   advance = tick_in;
  end

  always_ff @(posedge clk) begin
    if (!reset || edit_mode || load_en || rate_changed || presc >= tc) begin
      presc <= '0;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  edit_op_t         op;
  logic [WIDTH-1:0] load_next;
  logic [WIDTH-1:0] edit_next;

  always_comb begin
    op = NONE;
    if (ev_plus && !ev_minus)      op = edit_sel ? TENS_INC : ONES_INC;
    else if (ev_minus && !ev_plus) op = edit_sel ? TENS_DEC : ONES_DEC;

    if (int'(load_val) < int'(MIN_VAL))      load_next = WIDTH'(MIN_VAL);
    else if (int'(load_val) > int'(MAX_VAL)) load_next = WIDTH'(MAX_VAL);
    else                                     load_next = load_val;

    edit_next = WIDTH'(apply_edit(op, int'(value), int'(MIN_VAL), int'(MAX_VAL)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      value     <= WIDTH'(MIN_VAL);
      carry_out <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      if (load_en) begin
        value <= load_next;
      end else if (edit_mode) begin
        value <= edit_next;
      end else if (advance) begin
        if (value == WIDTH'(MAX_VAL)) begin
          value     <= WIDTH'(MIN_VAL);
          carry_out <= 1'b1;
        end else begin
          value <= value + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_time_unit_counter.sv
// Bench for time_unit_counter: three instances share one stimulus stream
//   A: 0..59, prescaler TC=3    B: 1..12, tick_in    C: 0..31, prescaler TC=5
// A cycle-level reference model of each instance is compared every cycle,
// and literal expectations pin the directed scenarios.
module tb_time_unit_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       tick_in;
  logic       edit_mode;
  logic       edit_sel;
  logic       key_plus;
  logic       key_minus;
  logic       load_en;
  logic [6:0] load_val;
`ifdef TIME_UNIT_DEBUG_RATE_EN
  logic [2:0] dbg_rate;
  logic [2:0] rate_prev = 3'd0;
`endif
  logic [6:0] val[3];
  logic       carry[3];

  time_unit_counter #(.MAX_VAL(59), .MIN_VAL(0), .WIDTH(7), .INT_PRESCALE(1), .TICK_TC(3)) u_a (
    .clk(clk), .reset(reset), .tick_in(tick_in), .edit_mode(edit_mode), .edit_sel(edit_sel),
    .key_plus(key_plus), .key_minus(key_minus), .load_en(load_en), .load_val(load_val),
`ifdef TIME_UNIT_DEBUG_RATE_EN
    .dbg_rate(dbg_rate),
`endif
    .value(val[0]), .carry_out(carry[0]));

  time_unit_counter #(.MAX_VAL(12), .MIN_VAL(1), .WIDTH(7), .INT_PRESCALE(0), .TICK_TC(3)) u_b (
    .clk(clk), .reset(reset), .tick_in(tick_in), .edit_mode(edit_mode), .edit_sel(edit_sel),
    .key_plus(key_plus), .key_minus(key_minus), .load_en(load_en), .load_val(load_val),
`ifdef TIME_UNIT_DEBUG_RATE_EN
    .dbg_rate(dbg_rate),
`endif
    .value(val[1]), .carry_out(carry[1]));

  time_unit_counter #(.MAX_VAL(31), .MIN_VAL(0), .WIDTH(7), .INT_PRESCALE(1), .TICK_TC(5)) u_c (
    .clk(clk), .reset(reset), .tick_in(tick_in), .edit_mode(edit_mode), .edit_sel(edit_sel),
    .key_plus(key_plus), .key_minus(key_minus), .load_en(load_en), .load_val(load_val),
`ifdef TIME_UNIT_DEBUG_RATE_EN
    .dbg_rate(dbg_rate),
`endif
    .value(val[2]), .carry_out(carry[2]));

  int pmin[3] = '{0, 1, 0};
  int pmax[3] = '{59, 12, 31};
  int ptc[3]  = '{3, 0, 5};
  bit pint[3] = '{1'b1, 1'b0, 1'b1};

  int mval[3];
  int mcarry[3];
  int mcnt[3];
  bit hist_ok = 1'b0;
  bit kp_prev = 1'b1;
  bit km_prev = 1'b1;
  bit checking = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int model_tc(input int i);
`ifdef TIME_UNIT_DEBUG_RATE_EN
    case (dbg_rate)
      3'd1: return 833_333;
      3'd2: return 13_888;
      3'd3: return 578;
      3'd4: return 19;
      3'd5: return 1;
      default: ;
    endcase
`endif
    return ptc[i];
  endfunction

  // op: 1 ones+, 2 ones-, 3 tens+, 4 tens-
  function automatic int edit_value(input int v, input int op, input int mn, input int mx);
    int ones;
    int tens;
    ones = v % 10;
    tens = v / 10;
    case (op)
      1: return (ones == 9 || v == mx) ? imax(mn, v - ones) : v + 1;
      2: return (ones == 0 || v == mn) ? tens * 10 + imin(9, mx - tens * 10) : v - 1;
      3: return (v + 10 > mx) ? imax(mn, ones) : v + 10;
      4: return (v - 10 < mn) ? imin(mx, (mx / 10) * 10 + ones) : v - 10;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    bit ep;
    bit em;
    bit rchg;
    int op;
    int tc;
    bit adv;
    ep = hist_ok && kp_prev && !key_plus;
    em = hist_ok && km_prev && !key_minus;
    op = 0;
    if (ep && !em)      op = edit_sel ? 3 : 1;
    else if (em && !ep) op = edit_sel ? 4 : 2;
    rchg = 1'b0;
`ifdef TIME_UNIT_DEBUG_RATE_EN
    rchg = (dbg_rate != rate_prev);
    rate_prev = dbg_rate;
`endif
    for (int i = 0; i < 3; i++) begin
      tc = model_tc(i);
      mcarry[i] = 0;
      if (!reset) begin
        mval[i] = pmin[i];
        mcnt[i] = 0;
      end else begin
        adv = pint[i] ? (mcnt[i] == tc && !rchg) : tick_in;
        if (load_en) begin
          mval[i] = imin(pmax[i], imax(pmin[i], int'(load_val)));
        end else if (edit_mode) begin
          mval[i] = edit_value(mval[i], op, pmin[i], pmax[i]);
        end else if (adv) begin
          mval[i] = (mval[i] - pmin[i] + 1) % (pmax[i] - pmin[i] + 1) + pmin[i];
          mcarry[i] = (mval[i] == pmin[i]) ? 1 : 0;
        end
        mcnt[i] = (edit_mode || load_en || rchg || mcnt[i] == tc) ? 0 : mcnt[i] + 1;
      end
    end
    hist_ok = reset;
    kp_prev = key_plus;
    km_prev = key_minus;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model_value[%0d]", i), int'(val[i]), mval[i]);
        check($sformatf("model_carry[%0d]", i), int'(carry[i]), mcarry[i]);
      end
    end
  end

  // Literal expectation on both the DUT and the model.
  task automatic lit(input int i, input string name, input int exp_val);
    check($sformatf("%s value[%0d]", name, i), int'(val[i]), exp_val);
    check($sformatf("%s model[%0d]", name, i), mval[i], exp_val);
  endtask

  task automatic litc(input int i, input string name, input int exp_c);
    check($sformatf("%s carry[%0d]", name, i), int'(carry[i]), exp_c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit plus, input bit minus);
    key_plus  = !plus;
    key_minus = !minus;
    tick(1);
    key_plus  = 1'b1;
    key_minus = 1'b1;
    tick(1);
  endtask

  task automatic load(input int v);
    load_en  = 1'b1;
    load_val = 7'(v);
    tick(1);
    load_en  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; tick_in = 1'b0; edit_mode = 1'b0; edit_sel = 1'b0;
    key_plus = 1'b1; key_minus = 1'b1; load_en = 1'b0; load_val = '0;
`ifdef TIME_UNIT_DEBUG_RATE_EN
    dbg_rate = 3'd0;
`endif
    tick(2);
    checking = 1'b1;
    lit(0, "reset", 0); lit(1, "reset", 1); lit(2, "reset", 0);
    litc(0, "reset", 0); litc(1, "reset", 0);
    reset = 1'b1;

    // Prescaled wrap on A (TC=3); B clamps 58 to 12 and wraps on tick_in.
    load(58);
    lit(0, "load58", 58); lit(1, "load58", 12);
    tick(4); lit(0, "adv1", 59); litc(0, "adv1", 0);
    tick(3); lit(0, "adv1_hold", 59);
    tick(1); lit(0, "wrap", 0); litc(0, "wrap", 1);
    tick(1); litc(0, "wrap_end", 0);
    lit(1, "b_pre_tick", 12);
    tick_in = 1'b1; tick(1); tick_in = 1'b0;
    lit(1, "b_wrap", 1); litc(1, "b_wrap", 1);
    tick(1); litc(1, "b_wrap_end", 0);

    // Digit edits, 1..12 on B.
    edit_mode = 1'b1;
    load(12);
    edit_sel = 1'b1;
    press(1'b1, 1'b0); lit(1, "tens_inc", 2);
    press(1'b0, 1'b1); lit(1, "tens_dec", 12);
    load(1);
    edit_sel = 1'b0;
    press(1'b0, 1'b1); lit(1, "ones_dec", 9);

    // Digit edits, 0..31 on C.
    load(31);
    press(1'b1, 1'b0); lit(2, "ones_inc", 30);
    press(1'b0, 1'b1); lit(2, "ones_dec", 31);
    press(1'b1, 1'b1); lit(2, "both_keys", 31); lit(0, "both_keys", 31);

    // Load clamping and load-over-key priority.
    load(75); lit(0, "clamp_hi", 59); lit(2, "clamp_hi", 31);
    load(0);  lit(1, "clamp_lo", 1);
    key_plus = 1'b0; load_en = 1'b1; load_val = 7'd20; tick(1);
    load_en = 1'b0; key_plus = 1'b1; tick(1);
    lit(0, "load_wins", 20); lit(1, "load_wins", 12);

    // tick_in during edit is dropped; prescaler restarts on exit.
    repeat (3) begin
      tick_in = 1'b1; tick(1); tick_in = 1'b0; tick(1);
    end
    edit_mode = 1'b0;
    tick(3);
    lit(1, "edit_drop", 12); litc(1, "edit_drop", 0); lit(0, "restart", 20);
    tick(1); lit(0, "restart_adv", 21);

    // Reset mid-count with a key held through reset release.
    key_plus = 1'b0; reset = 1'b0; tick(1);
    lit(0, "mid_reset", 0); lit(1, "mid_reset", 1); lit(2, "mid_reset", 0);
    litc(0, "mid_reset", 0); litc(1, "mid_reset", 0); litc(2, "mid_reset", 0);
    reset = 1'b1; edit_mode = 1'b1; edit_sel = 1'b0; tick(3);
    lit(1, "held_key", 1); lit(0, "held_key", 0);
    key_plus = 1'b1; tick(1);
    press(1'b1, 1'b0); lit(1, "key_after_reset", 2);

`ifdef TIME_UNIT_DEBUG_RATE_EN
    edit_mode = 1'b0; dbg_rate = 3'd5;
    load(0);
    tick(4); lit(0, "dbg5", 2);
    dbg_rate = 3'd4;
    tick(20); lit(0, "dbg4_hold", 2);
    tick(1);  lit(0, "dbg4_adv", 3);
    dbg_rate = 3'd0;
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 199) != 0);
      load_en   = ($urandom_range(0, 29) == 0);
      load_val  = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 39) == 0) edit_mode = !edit_mode;
      edit_sel  = 1'($urandom_range(0, 1));
      key_plus  = ($urandom_range(0, 3) != 0);
      key_minus = ($urandom_range(0, 3) != 0);
      tick_in   = ($urandom_range(0, 2) == 0);
`ifdef TIME_UNIT_DEBUG_RATE_EN
      if ($urandom_range(0, 99) == 0) dbg_rate = ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd0;
`endif
      tick(1);
    end

    tick(2);
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_unit_counter.md
TIME_UNIT_COUNTER -- requirements
Module: time_unit_counter

Interface
REQ-001 Parameter MAX_VAL, default 59: highest legal value (inclusive).
REQ-002 Parameter MIN_VAL, default 0: lowest legal value (1 for day/month units).
REQ-003 Parameter WIDTH, default 7: value width, ≥ clog2(MAX_VAL+1).
REQ-004 Parameter INT_PRESCALE, default 1: 1 = advance from internal prescaler; 0 = advance from tick_in.
REQ-005 Parameter TICK_TC, default 49_999_999: prescaler terminal count (period TICK_TC+1 clocks).
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 tick_in  input  1  one-cycle advance pulse from lower unit (used when INT_PRESCALE=0).
REQ-009 edit_mode  input  1  1 = edit, counting frozen.
REQ-010 edit_sel  input  1  0 = ones digit, 1 = tens digit.
REQ-011 key_plus / key_minus  input  1 each  active-low keys, edge-detected inside.
REQ-012 load_en  input  1  synchronous preset strobe; load_val  input  WIDTH  preset value.
REQ-013 dbg_rate  input  3  debug speed select (only with DEBUG_RATE_EN).
REQ-014 value  output  WIDTH  current registered value; carry_out  output  1  registered one-cycle wrap pulse.

Function
REQ-015 Per-edge priority SHALL be: reset > load_en > key event (edit_mode=1) > advance (edit_mode=0).
REQ-016 Prescaler (INT_PRESCALE=1) SHALL count 0..TC and assert advance on the cycle count==TC, then return to 0; held at 0 while edit_mode=1 or load_en=1.
REQ-017 Advance: value==MAX_VAL -> MIN_VAL with carry_out=1 next cycle, else value+1, carry_out=0.
REQ-018 carry_out SHALL never assert in edit mode, on load, or on key edits.
REQ-019 Key event = registered previous key 1 and current key 0; both keys falling same cycle -> no change.
REQ-020 Ones +: if ones==9 or value==MAX_VAL, value-ones (then raise to MIN_VAL if below); else value+1.
REQ-021 Ones -: if ones==0 or value==MIN_VAL, set ones to min(9, MAX_VAL-tens*10); else value-1.
REQ-022 Tens +: if value+10 > MAX_VAL, value%10 (raised to MIN_VAL if below); else value+10.
REQ-023 Tens -: if value-10 < MIN_VAL (signed compare), floor(MAX_VAL/10)*10+ones, clamped to MAX_VAL; else value-10.
REQ-024 load_en SHALL set value to load_val clamped into [MIN_VAL, MAX_VAL] next cycle.
REQ-025 tick_in and prescaler advances arriving while edit_mode=1 SHALL be discarded, not queued.
REQ-026 Leaving edit mode SHALL restart prescaler from 0; first advance TC+1 cycles later.

Reset
REQ-027 reset=0 at clk edge: value=MIN_VAL, carry_out=0, prescaler=0, key history=1 (released).
REQ-028 Reset mid-count or mid-key-press SHALL not produce a key event on release of reset while key is still held.

Configuration
REQ-029 Macro TIME_UNIT_DEBUG_RATE_EN defined: dbg_rate present; TC = package table entry (0 = TICK_TC, 1..5 = minute/hour/day/month/year debug TCs); dbg_rate change resets prescaler.
REQ-030 Macro undefined: dbg_rate port absent, TC = TICK_TC fixed.

Structure
REQ-031 Package time_counter_pkg SHALL hold debug TC constants (833_333, 13_888, 578, 19, 1), the real-time TC (49_999_999), and the edit-op enum (NONE, ONES_INC, ONES_DEC, TENS_INC, TENS_DEC).
REQ-032 One sub-module key_edge_detect (per key: history register, falling-edge pulse) SHALL be instantiated twice.

Verification
REQ-033 TC=3, MIN 0, MAX 59, value 58: advances every 4 clocks -> 59, then 0 with carry_out high exactly 1 cycle.
REQ-034 MIN 1, MAX 12, edit, value 12, tens + -> 2; value 2, tens - -> 12; value 1, ones - -> 9.
REQ-035 MAX 31, value 31, ones + -> 30; value 30, ones - -> 31; both keys fall same cycle -> unchanged.
REQ-036 load_val 75 (MAX 59) -> 59; load_val 0 with MIN 1 -> 1; load and key same cycle -> load wins.
REQ-037 tick_in pulses during edit_mode -> value and carry_out unchanged after exit; reset asserted mid-count -> value MIN_VAL, carry_out 0 next edge.
REQ-038 With TIME_UNIT_DEBUG_RATE_EN, dbg_rate=5 -> advance every 2 clocks; switch to 4 -> prescaler restarts, advance every 20 clocks.
